// File: rtl/passcode_tx.sv
`default_nettype none
// ============================================================================
// Module   : passcode_tx
// Purpose  : Serializes a captured passcode to a guard over a four-phase
//            rq/ak handshake, LANES bits per beat. Defining the macro
//            PASSCODE_TX_TIMEOUT_EN bounds each handshake wait by TO_CYCLES.
// Revision : 1.0 - initial release
// ============================================================================
module passcode_tx #(
  parameter int WIDTH     = 16,
  parameter int LANES     = 1,
  parameter int MSB_FIRST = 1,
  parameter int TO_CYCLES = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rd,
  input  logic             ak,
  input  logic             en,
  input  logic [WIDTH-1:0] passcode,
  output logic             rq,
  output logic [LANES-1:0] dout,
  output logic             beat_done,
  output logic             done,
  output logic             busy,
  output logic             to_err
);

  localparam int c_beats = WIDTH / LANES;
  localparam int c_cw    = (c_beats > 1) ? $clog2(c_beats) : 1;
  localparam logic [c_cw-1:0] c_last = c_cw'(c_beats - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    DRIVE   = 3'd2,
    WAIT_HI = 3'd3,
    WAIT_LO = 3'd4,
    NEXT    = 3'd5
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_rq;
  logic              w_rq_nxt;
  logic [LANES-1:0]  r_dout;
  logic [LANES-1:0]  w_dout_nxt;
  logic              r_beat_done;
  logic              w_beat_done_nxt;
  logic              r_done;
  logic              w_done_nxt;
  logic [WIDTH-1:0]  r_sr;
  logic [WIDTH-1:0]  w_sr_nxt;
  logic [c_cw-1:0]   r_cnt;
  logic [c_cw-1:0]   w_cnt_nxt;
  logic [LANES-1:0]  w_lane;
  logic [WIDTH-1:0]  w_shifted;

  // The sending end of the shift register is fixed at build time.
  generate
    if (MSB_FIRST != 0) begin : g_msb_first
      assign w_lane    = r_sr[WIDTH-1 -: LANES];
      assign w_shifted = r_sr << LANES;
    end else begin : g_lsb_first
      assign w_lane    = r_sr[LANES-1:0];
      assign w_shifted = r_sr >> LANES;
    end
  endgenerate

`ifdef PASSCODE_TX_TIMEOUT_EN
  localparam int c_tw = (TO_CYCLES > 1) ? $clog2(TO_CYCLES) : 1;
  localparam logic [c_tw-1:0] c_to_last = c_tw'(TO_CYCLES - 1);

  logic [c_tw-1:0] r_to;
  logic [c_tw-1:0] w_to_nxt;
  logic            r_to_err;
  logic            w_to_err_nxt;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_rq_nxt        = r_rq;
    w_dout_nxt      = r_dout;
    w_sr_nxt        = r_sr;
    w_cnt_nxt       = r_cnt;
    w_beat_done_nxt = 1'b0;
    w_done_nxt      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (rd && en) begin
          w_cnt_nxt   = '0;
          w_state_nxt = LOAD;
        end
      end
      LOAD: begin
        w_sr_nxt    = passcode;
        w_state_nxt = DRIVE;
      end
      DRIVE: begin
        // A still-high ak belongs to an earlier handshake; never overlap it.
        if (!ak) begin
          w_dout_nxt  = w_lane;
          w_rq_nxt    = 1'b1;
          w_state_nxt = WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (ak) begin
          w_rq_nxt    = 1'b0;
          w_state_nxt = WAIT_LO;
        end
      end
      WAIT_LO: begin
        if (!ak) begin
          w_beat_done_nxt = 1'b1;
          w_state_nxt     = NEXT;
        end
      end
      NEXT: begin
        w_sr_nxt = w_shifted;
        if (r_cnt == c_last) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt   = r_cnt + 1'b1;
          w_state_nxt = DRIVE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase

`ifdef PASSCODE_TX_TIMEOUT_EN
    w_to_nxt     = '0;
    w_to_err_nxt = 1'b0;
    // Counter only advances while a wait state holds; any transition clears it.
    if ((r_state == WAIT_HI && !ak) || (r_state == WAIT_LO && ak)) begin
      if (r_to == c_to_last) begin
        w_rq_nxt        = 1'b0;
        w_to_err_nxt    = 1'b1;
        w_done_nxt      = 1'b0;
        w_beat_done_nxt = 1'b0;
        w_state_nxt     = IDLE;
      end else begin
        w_to_nxt = r_to + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rq        <= 1'b0;
      r_dout      <= '0;
      r_beat_done <= 1'b0;
      r_done      <= 1'b0;
      r_sr        <= '0;
      r_cnt       <= '0;
    end else begin
      r_rq        <= w_rq_nxt;
      r_dout      <= w_dout_nxt;
      r_beat_done <= w_beat_done_nxt;
      r_done      <= w_done_nxt;
      r_sr        <= w_sr_nxt;
      r_cnt       <= w_cnt_nxt;
    end
  end

`ifdef PASSCODE_TX_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_to     <= '0;
      r_to_err <= 1'b0;
    end else begin
      r_to     <= w_to_nxt;
      r_to_err <= w_to_err_nxt;
    end
  end

  assign to_err = r_to_err;
`else
  assign to_err = 1'b0;
`endif

  assign rq        = r_rq;
  assign dout      = r_dout;
  assign beat_done = r_beat_done;
  assign done      = r_done;
  assign busy      = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_passcode_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_passcode_tx
// Purpose  : Directed, table-driven bench for passcode_tx (1-lane MSB-first
//            and 4-lane LSB-first instances sharing rd/en/passcode).
// Revision : 1.0 - initial release
// ============================================================================
module tb_passcode_tx;

  typedef struct {
    logic [15:0] pc;
    logic [15:0] exp_word;
    logic        exp_last;
    logic [15:0] exp4;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        rd;
  logic        en;
  logic [15:0] passcode;
  logic        ak;
  logic        rq;
  logic [0:0]  dout;
  logic        beat_done;
  logic        done;
  logic        busy;
  logic        to_err;
  logic        ak4;
  logic        rq4;
  logic [3:0]  dout4;
  logic        beat_done4;
  logic        done4;
  logic        busy4;
  logic        to_err4;

  int total = 0;
  int bad   = 0;

  int          nrise, nbd, ndone, nto;
  int          nbd4, ndone4;
  logic [15:0] word, word4;
  logic        rq_p, rq4_p;
  bit          g_auto;

  passcode_tx #(.WIDTH(16), .LANES(1), .MSB_FIRST(1), .TO_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n), .rd(rd), .ak(ak), .en(en), .passcode(passcode),
    .rq(rq), .dout(dout), .beat_done(beat_done), .done(done), .busy(busy),
    .to_err(to_err)
  );

  passcode_tx #(.WIDTH(16), .LANES(4), .MSB_FIRST(0)) dut4 (
    .clk(clk), .rst_n(rst_n), .rd(rd), .ak(ak4), .en(en), .passcode(passcode),
    .rq(rq4), .dout(dout4), .beat_done(beat_done4), .done(done4), .busy(busy4),
    .to_err(to_err4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Guard models: ack two cycles after rq, release once rq drops.
  initial begin
    int gc, gc4;
    gc = 0; gc4 = 0; ak = 1'b0; ak4 = 1'b0;
    forever begin
      @(negedge clk);
      if (g_auto) begin
        if (rq && !ak) begin
          gc++;
          if (gc >= 2) begin ak = 1'b1; gc = 0; end
        end else begin
          gc = 0;
          if (!rq) ak = 1'b0;
        end
      end
      if (rq4 && !ak4) begin
        gc4++;
        if (gc4 >= 2) begin ak4 = 1'b1; gc4 = 0; end
      end else begin
        gc4 = 0;
        if (!rq4) ak4 = 1'b0;
      end
    end
  end

  // Monitor: reassemble the transmitted word from the value on each rq rise.
  initial begin
    rq_p = 1'b0; rq4_p = 1'b0;
    nrise = 0; nbd = 0; ndone = 0; nto = 0; nbd4 = 0; ndone4 = 0;
    word = '0; word4 = '0;
    forever begin
      @(negedge clk);
      if (rq && !rq_p) begin word = {word[14:0], dout[0]}; nrise++; end
      if (rq4 && !rq4_p) word4 = {word4[11:0], dout4};
      rq_p  = rq;
      rq4_p = rq4;
      if (beat_done)  nbd++;
      if (done)       ndone++;
      if (to_err)     nto++;
      if (beat_done4) nbd4++;
      if (done4)      ndone4++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_counts();
    @(posedge clk); #1;
    nrise = 0; nbd = 0; ndone = 0; nto = 0; nbd4 = 0; ndone4 = 0;
    word = '0; word4 = '0;
  endtask

  // Starts a frame, checks start latency, then scrambles inputs after capture.
  task automatic start_and_track(input logic [15:0] pc);
    @(negedge clk);
    passcode = pc; rd = 1'b1; en = 1'b1;
    @(negedge clk);
    chk("start_busy", busy, 1);
    chk("start_rq_low", rq, 0);
    @(negedge clk);
    passcode = ~pc; rd = 1'b0; en = 1'b0;
    chk("load_rq_low", rq, 0);
    @(negedge clk);
    chk("first_rq_third_edge", rq, 1);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (ndone == 0 && nto == 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      total++; bad++;
      $display("FAIL frame_end: got no done within %0d cycles, required done", n);
    end
  endtask

  task automatic run_frame(input vec_t v);
    clear_counts();
    start_and_track(v.pc);
    wait_done();
    repeat (3) @(negedge clk);
    chk("word", word, v.exp_word);
    chk("rq_rises", nrise, 16);
    chk("beat_done_cnt", nbd, 16);
    chk("done_cnt", ndone, 1);
    chk("to_err_cnt", nto, 0);
    chk("idle_busy", busy, 0);
    chk("idle_rq", rq, 0);
    chk("dout_hold", dout, v.exp_last);
    chk("word4", word4, v.exp4);
    chk("beat_done4_cnt", nbd4, 4);
    chk("done4_cnt", ndone4, 1);
    chk("dout4_hold", dout4, v.exp4[3:0]);
  endtask

  initial begin
    vec_t vec[6];
    vec_t v;
    bit   hold_bad;
    int   n;
    vec[0] = '{pc: 16'hA5C3, exp_word: 16'hA5C3, exp_last: 1'b1, exp4: 16'h3C5A};
    vec[1] = '{pc: 16'h1234, exp_word: 16'h1234, exp_last: 1'b0, exp4: 16'h4321};
    vec[2] = '{pc: 16'h0001, exp_word: 16'h0001, exp_last: 1'b1, exp4: 16'h1000};
    vec[3] = '{pc: 16'h8000, exp_word: 16'h8000, exp_last: 1'b0, exp4: 16'h0008};
    vec[4] = '{pc: 16'hFFFF, exp_word: 16'hFFFF, exp_last: 1'b1, exp4: 16'hFFFF};
    vec[5] = '{pc: 16'h0000, exp_word: 16'h0000, exp_last: 1'b0, exp4: 16'h0000};

    g_auto = 1'b1;
    rst_n = 1'b0; rd = 1'b0; en = 1'b0; passcode = '0;
    #2;
    chk("rst_rq", rq, 0);
    chk("rst_dout", dout, 0);
    chk("rst_beat_done", beat_done, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_to_err", to_err, 0);
    chk("rst_dout4", dout4, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) run_frame(vec[i]);

    // Asynchronous reset while beat 5 waits for its ack.
    clear_counts();
    start_and_track(16'h0F0F);
    n = 0;
    while (nrise < 5 && n < 200) begin @(negedge clk); n++; end
    chk("rst_mid_pre_rq", rq, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_rq", rq, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_dout", dout, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("rst_mid_no_done", ndone, 0);
    chk("rst_mid_beats", nbd, 4);
    chk("rst_mid_stays_idle", busy, 0);
    run_frame(vec[0]);

    // ak held high across the last NEXT -> IDLE with an immediate restart.
    clear_counts();
    start_and_track(16'h3C96);
    n = 0;
    while (!(beat_done && nrise == 16) && n < 200) begin @(negedge clk); n++; end
    chk("akhold_last_beat", beat_done, 1);
    g_auto = 1'b0; ak = 1'b1; rd = 1'b1; en = 1'b1; passcode = 16'h5AA5;
    hold_bad = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (rq) hold_bad = 1'b1;
    end
    chk("akhold_no_rq", hold_bad, 0);
    chk("akhold_busy", busy, 1);
    chk("akhold_prev_word", word, 16'h3C96);
    chk("akhold_prev_done", ndone, 1);
    clear_counts();
    @(negedge clk);
    ak = 1'b0; rd = 1'b0; en = 1'b0;
    @(negedge clk);
    chk("akhold_rq_after_low", rq, 1);
    g_auto = 1'b1;
    wait_done();
    repeat (3) @(negedge clk);
    chk("akhold_word", word, 16'h5AA5);
    chk("akhold_done", ndone, 1);
    chk("akhold_rises", nrise, 16);

`ifdef PASSCODE_TX_TIMEOUT_EN
    // ak never answers: expect abort 8 cycles after WAIT_HI entry.
    repeat (40) @(negedge clk);
    clear_counts();
    g_auto = 1'b0; ak = 1'b0;
    start_and_track(16'h8001);
    repeat (7) @(negedge clk);
    chk("to_rq_before", rq, 1);
    chk("to_err_before", to_err, 0);
    @(negedge clk);
    chk("to_rq_fall", rq, 0);
    chk("to_err_pulse", to_err, 1);
    chk("to_busy", busy, 0);
    repeat (4) @(negedge clk);
    chk("to_no_done", ndone, 0);
    chk("to_err_once", nto, 1);
    g_auto = 1'b1;
`endif

    repeat (40) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/passcode_tx.md
PASSCODE_TX -- requirements
Module: passcode_tx

Interface
REQ-001 Parameter WIDTH, default 16, passcode length in bits (>=2).
REQ-002 Parameter LANES, default 1, bits per beat; WIDTH SHALL be a multiple of LANES; BEATS = WIDTH/LANES.
REQ-003 Parameter MSB_FIRST, default 1, 1 = send most-significant lane first, 0 = least-significant first.
REQ-004 Parameter TO_CYCLES, default 255, handshake timeout limit in clk cycles (used only under REQ-027).
REQ-005 clk  in  1  single clock, all state on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous and active-low.
REQ-007 rd  in  1  guard ready.
REQ-008 ak  in  1  guard acknowledge, four-phase.
REQ-009 en  in  1  transmit enable.
REQ-010 passcode  in  WIDTH  word to send.
REQ-011 rq  out  1  request, registered.
REQ-012 dout  out  LANES  data beat, registered, stable whenever rq=1.
REQ-013 beat_done  out  1  one-cycle pulse per completed beat.
REQ-014 done  out  1  one-cycle pulse when the whole frame completes.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 to_err  out  1  one-cycle pulse on handshake timeout.

Function
REQ-017 FSM states SHALL be IDLE, LOAD, DRIVE, WAIT_HI, WAIT_LO, NEXT.
REQ-018 IDLE: rd=1 and en=1 on an edge -> LOAD, beat counter cleared to 0; otherwise stay.
REQ-019 LOAD: passcode captured into a WIDTH-bit shift register -> DRIVE; later passcode changes SHALL NOT affect the frame.
REQ-020 DRIVE: dout <= current lane (top LANES bits if MSB_FIRST, else bottom LANES bits), rq <= 1 -> WAIT_HI; first rq rises 3 edges after the start condition is sampled.
REQ-021 WAIT_HI: while ak=0 stay; on ak=1, rq <= 0 -> WAIT_LO.
REQ-022 WAIT_LO: while ak=1 stay; on ak=0, beat_done pulses -> NEXT.
REQ-023 NEXT: shift register shifts by LANES toward the sending end, zero fill; counter increments; if counter was BEATS-1 -> IDLE with done pulsing that cycle, else -> DRIVE.
REQ-024 dout SHALL hold its last value after the frame; rq SHALL never be 1 while ak is still high from the previous beat.
REQ-025 en or rd deasserting mid-frame SHALL NOT abort the frame; they are sampled only in IDLE.
REQ-026 Counter width SHALL be clog2(BEATS), minimum 1; it SHALL NOT wrap within a frame.

Configuration
REQ-027 With macro PASSCODE_TX_TIMEOUT_EN defined, a counter SHALL run in WAIT_HI and WAIT_LO, clear on each state entry, and on reaching TO_CYCLES force rq <= 0, pulse to_err, skip done, and go to IDLE; without the macro, waits are unbounded, no timeout counter exists, and to_err is tied 0.

Reset
REQ-028 rst_n=0 SHALL immediately force state IDLE, rq=0, dout=0, beat_done=0, done=0, busy=0, to_err=0, counter=0, shift register=0.
REQ-029 Reset mid-frame SHALL abandon the frame with no done pulse; after release the block waits for a new start in IDLE.

Verification
REQ-030 Defaults, passcode 16'hA5C3, guard acks 2 cycles after rq -> 16 beats, dout sequence 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1, 16 beat_done, one done.
REQ-031 LANES=4, MSB_FIRST=0, passcode 16'h1234 -> dout 4'h4,4'h3,4'h2,4'h1, then done.
REQ-032 passcode changed to 16'hFFFF one cycle after LOAD -> transmitted word still the captured value.
REQ-033 rst_n pulsed low during WAIT_HI of beat 5 -> rq=0 immediately, no done, next frame sends full 16 beats correctly.
REQ-034 PASSCODE_TX_TIMEOUT_EN defined, TO_CYCLES=8, ak never asserted -> rq falls and to_err pulses 8 cycles after WAIT_HI entry, busy=0, done never pulses.
REQ-035 ak held high across the final NEXT/IDLE transition, rd=en=1 -> next frame's first rq rises only after ak has been low.
